// File: rtl/alu_sequencer_pkg.sv
// ============================================================================
// alu_sequencer_pkg : opcodes, FSM encodings and counter sizing for alu_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_SHR  = 2'b00,
    OP_SHL  = 2'b01,
    OP_ZERO = 2'b10,
    OP_DIV  = 2'b11
  } op_e;

  typedef logic [2:0] state_t;

  localparam state_t C_ST_IDLE  = 3'd0;
  localparam state_t C_ST_LOAD  = 3'd1;
  localparam state_t C_ST_SHIFT = 3'd2;
  localparam state_t C_ST_WAIT  = 3'd3;
  localparam state_t C_ST_CAPT  = 3'd4;
  localparam state_t C_ST_DONE  = 3'd5;

  // One spare bit above the largest value ever loaded keeps the counters wrap-free.
  function automatic int cnt_width(input int div_lat, input int sh_gap, input int w);
    int m;
    m = div_lat;
    if (sh_gap > m) m = sh_gap;
    if ((1 << w) > m) m = (1 << w);
    return $clog2(m) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_sequencer_if.sv
// ============================================================================
// alu_sequencer_if : request, datapath-control and result handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface alu_sequencer_if #(
  parameter int W  = 3,
  parameter int RW = 4
);

  logic          start;
  logic [1:0]    op_in;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic          ready;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [1:0]    alu_op;
  logic          alu_init;
  logic          sh_now;
  logic [RW-1:0] dp_result;
  logic [RW-1:0] result;
  logic          res_valid;
  logic          res_ack;
  logic          err;

  modport master (
    output start, op_in, a_in, b_in, dp_result, res_ack,
    input  ready, alu_a, alu_b, alu_op, alu_init, sh_now, result, res_valid, err
  );

  modport slave (
    input  start, op_in, a_in, b_in, dp_result, res_ack,
    output ready, alu_a, alu_b, alu_op, alu_init, sh_now, result, res_valid, err
  );

endinterface

`default_nettype wire

// File: rtl/alu_sequencer_lat_timer.sv
// ============================================================================
// alu_sequencer_lat_timer : loadable down-counter that saturates at zero
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_sequencer_lat_timer #(
  parameter int WIDTH = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_load,
  input  wire logic [WIDTH-1:0] i_load_val,
  input  wire logic             i_en,
  output logic                  o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// alu_sequencer : freezes one ALU request, strobes/pulses the datapath, holds result
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int W        = 3,
  parameter int RW       = 4,
  parameter int DIV_LAT  = 8,
  parameter int ZERO_LAT = 2,
  parameter int SH_GAP   = 4
) (
  input  wire logic     clk,
  input  wire logic     rst,
  alu_sequencer_if.slave bus
);

  localparam int CW = cnt_width(DIV_LAT, SH_GAP, W);

  state_t        r_state;
  state_t        w_next_state;
  logic [W-1:0]  r_alu_a;
  logic [W-1:0]  r_alu_b;
  logic [1:0]    r_alu_op;
  logic [CW-1:0] r_shcnt;
  logic [RW-1:0] r_result;
  logic          r_res_valid;
  logic          r_err;

  logic          w_ready;
  logic          w_alu_init;
  logic          w_sh_now;
  logic          w_accept;
  logic          w_is_shift;
  logic          w_b_zero;
  logic          w_tmr_load;
  logic          w_tmr_en;
  logic [CW-1:0] w_tmr_val;
  logic          w_tmr_zero;

  assign w_is_shift = ~r_alu_op[1];
  assign w_b_zero   = (r_alu_b == '0);
  assign w_accept   = bus.start & w_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= C_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      C_ST_IDLE: begin
        if (w_accept) w_next_state = C_ST_LOAD;
      end
      C_ST_LOAD: begin
        if (w_is_shift) begin
          w_next_state = w_b_zero ? C_ST_CAPT : C_ST_SHIFT;
        end else if (r_alu_op == OP_ZERO) begin
          w_next_state = C_ST_WAIT;
        end else begin
          w_next_state = w_b_zero ? C_ST_CAPT : C_ST_WAIT;
        end
      end
      C_ST_SHIFT: begin
        if (w_tmr_zero && (r_shcnt == '0)) w_next_state = C_ST_CAPT;
      end
      C_ST_WAIT: begin
        if (w_tmr_zero) w_next_state = C_ST_CAPT;
      end
      C_ST_CAPT: w_next_state = C_ST_DONE;
      C_ST_DONE: begin
        if (bus.res_ack) w_next_state = C_ST_IDLE;
      end
      default: w_next_state = C_ST_IDLE;
    endcase
  end

  always_comb begin
    w_ready    = (r_state == C_ST_IDLE);
    w_alu_init = (r_state == C_ST_LOAD);
    w_sh_now   = (r_state == C_ST_SHIFT) && w_tmr_zero && (r_shcnt != '0);
  end

  // The gap before the first pulse is one cycle longer than between pulses, and the
  // tail after the last pulse one cycle shorter, so CAPT lands (n+1)*SH_GAP after LOAD+1.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_en   = 1'b0;
    w_tmr_val  = '0;
    case (r_state)
      C_ST_LOAD: begin
        w_tmr_load = 1'b1;
        if (w_is_shift) begin
          w_tmr_val = CW'(SH_GAP);
        end else if (r_alu_op == OP_ZERO) begin
          w_tmr_val = CW'(ZERO_LAT - 1);
        end else begin
          w_tmr_val = CW'(DIV_LAT - 1);
        end
      end
      C_ST_SHIFT: begin
        if (w_sh_now) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = (r_shcnt == CW'(1)) ? CW'(SH_GAP - 2) : CW'(SH_GAP - 1);
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      C_ST_WAIT: w_tmr_en = 1'b1;
      default: begin
        w_tmr_load = 1'b0;
      end
    endcase
  end

  alu_sequencer_lat_timer #(
    .WIDTH (CW)
  ) u_lat_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_en       (w_tmr_en),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_shcnt     <= '0;
      r_result    <= '0;
      r_res_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu_a     <= bus.a_in;
        r_alu_b     <= bus.b_in;
        r_alu_op    <= bus.op_in;
        r_res_valid <= 1'b0;
        r_err       <= 1'b0;
      end else if (bus.res_ack && ((r_state == C_ST_DONE) || (r_state == C_ST_IDLE))) begin
        r_res_valid <= 1'b0;
      end
      if (r_state == C_ST_LOAD) begin
        r_shcnt <= CW'(r_alu_b);
        r_err   <= (r_alu_op == OP_DIV) && w_b_zero;
      end
      if (w_sh_now) begin
        r_shcnt <= r_shcnt - 1'b1;
      end
      if (r_state == C_ST_CAPT) begin
        r_result    <= r_err ? '0 : bus.dp_result;
        r_res_valid <= 1'b1;
      end
    end
  end

  assign bus.ready     = w_ready;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_op    = r_alu_op;
  assign bus.alu_init  = w_alu_init;
  assign bus.sh_now    = w_sh_now;
  assign bus.result    = r_result;
  assign bus.res_valid = r_res_valid;
  assign bus.err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// tb_alu_sequencer : directed vectors with a queue scoreboard and negedge monitor
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  localparam int W  = 3;
  localparam int RW = 4;

  typedef struct packed {
    logic [RW-1:0] res;
    logic          err;
    logic [31:0]   at;
  } want_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic prev_valid = 1'b0;

  want_t res_q[$];
  int    init_q[$];
  int    sh_q[$];

  alu_sequencer_if #(.W(W), .RW(RW)) bus ();

  alu_sequencer #(
    .W        (W),
    .RW       (RW),
    .DIV_LAT  (8),
    .ZERO_LAT (2),
    .SH_GAP   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests = n_tests + 1;
    if (act !== want) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic fail(input string msg);
    n_tests = n_tests + 1;
    n_fail  = n_fail + 1;
    $display("FAIL %s", msg);
  endtask

  // Monitor: every alu_init, sh_now and res_valid rise must match the next queued entry.
  always @(negedge clk) begin
    if (!rst) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.alu_init) begin
        if (init_q.size() > 0) chk("alu_init cycle", cyc, init_q.pop_front());
        else fail($sformatf("unexpected alu_init: got pulse at cycle %0d, expected none", cyc));
      end
      if (bus.sh_now) begin
        if (sh_q.size() > 0) chk("sh_now cycle", cyc, sh_q.pop_front());
        else fail($sformatf("unexpected sh_now: got pulse at cycle %0d, expected none", cyc));
      end
      if (bus.res_valid && !prev_valid) begin
        if (res_q.size() > 0) begin
          want_t w;
          w = res_q.pop_front();
          chk("result", 32'(bus.result), 32'(w.res));
          chk("err", 32'(bus.err), 32'(w.err));
          chk("res_valid cycle", cyc, w.at);
        end else begin
          fail($sformatf("unexpected res_valid: got rise at cycle %0d, expected none", cyc));
        end
      end
      prev_valid = bus.res_valid;
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, " ready"}, 32'(bus.ready), 1);
    chk({tag, " alu_a"}, 32'(bus.alu_a), 0);
    chk({tag, " alu_b"}, 32'(bus.alu_b), 0);
    chk({tag, " alu_op"}, 32'(bus.alu_op), 0);
    chk({tag, " alu_init"}, 32'(bus.alu_init), 0);
    chk({tag, " sh_now"}, 32'(bus.sh_now), 0);
    chk({tag, " result"}, 32'(bus.result), 0);
    chk({tag, " res_valid"}, 32'(bus.res_valid), 0);
    chk({tag, " err"}, 32'(bus.err), 0);
  endtask

  // Drive one start cycle and queue what the monitor must see; returns the start cycle.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [RW-1:0] dp, input logic [RW-1:0] er, input logic ee,
                       input int lat, input int nsh, input logic with_ack, input logic push_res,
                       output int c0);
    want_t w;
    @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.op_in     = op;
    bus.a_in      = a;
    bus.b_in      = b;
    bus.dp_result = dp;
    bus.res_ack   = with_ack;
    c0 = cyc;
    init_q.push_back(c0 + 1);
    for (int k = 1; k <= nsh; k++) sh_q.push_back(c0 + 2 + 4 * k);
    if (push_res) begin
      w.res = er;
      w.err = ee;
      w.at  = 32'(c0 + lat);
      res_q.push_back(w);
    end
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.res_ack = 1'b0;
    bus.a_in    = ~a;
    bus.b_in    = ~b;
    bus.op_in   = ~op;
  endtask

  task automatic wait_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.res_valid) seen = 1'b1;
    end
    if (!seen) fail($sformatf("%s timeout: got no res_valid in 60 cycles, expected one", name));
  endtask

  // Raised on the negedge of the cycle res_valid rose, so it is sampled that same cycle.
  task automatic ack_now(input string name);
    bus.res_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ack = 1'b0;
    @(negedge clk);
    chk({name, " ready after ack"}, 32'(bus.ready), 1);
    chk({name, " res_valid after ack"}, 32'(bus.res_valid), 0);
  endtask

  initial begin
    int c0;
    bus.start     = 1'b0;
    bus.op_in     = 2'b00;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.dp_result = '0;
    bus.res_ack   = 1'b0;

    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    #2 rst = 1'b1;

    issue(OP_SHR, 3'd6, 3'd3, 4'd0, 4'd0, 1'b0, 19, 3, 1'b0, 1'b1, c0);
    wait_valid("shr6by3");
    ack_now("shr6by3");

    issue(OP_DIV, 3'd7, 3'd2, 4'd3, 4'd3, 1'b0, 11, 0, 1'b0, 1'b1, c0);
    wait_valid("div7by2");
    ack_now("div7by2");

    issue(OP_SHL, 3'd2, 3'd5, 4'd0, 4'd0, 1'b0, 0, 2, 1'b0, 1'b0, c0);
    while (cyc < c0 + 11) begin
      @(posedge clk);
      #1;
    end
    #2 rst = 1'b0;
    @(negedge clk);
    check_reset_values("midshift reset");
    #2 rst = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    chk("midshift pending pulses", 32'(sh_q.size()), 0);
    chk("midshift ready", 32'(bus.ready), 1);

    issue(OP_DIV, 3'd5, 3'd0, 4'hF, 4'd0, 1'b1, 3, 0, 1'b0, 1'b1, c0);
    wait_valid("div_by_zero");
    ack_now("div_by_zero");

    issue(OP_ZERO, 3'd0, 3'd4, 4'd1, 4'd1, 1'b0, 5, 0, 1'b0, 1'b1, c0);
    wait_valid("zero_a0");
    ack_now("zero_a0");

    issue(OP_DIV, 3'd6, 3'd3, 4'd2, 4'd2, 1'b0, 11, 0, 1'b0, 1'b1, c0);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op_in = 2'b00;
    bus.a_in  = 3'd1;
    bus.b_in  = 3'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("wait start alu_a", 32'(bus.alu_a), 6);
    chk("wait start alu_b", 32'(bus.alu_b), 3);
    chk("wait start alu_op", 32'(bus.alu_op), 3);
    chk("wait start ready", 32'(bus.ready), 0);
    wait_valid("div6by3");
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op_in = 2'b01;
    bus.a_in  = 3'd5;
    bus.b_in  = 3'd0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("done start alu_a", 32'(bus.alu_a), 6);
    chk("done start alu_op", 32'(bus.alu_op), 3);
    chk("done start res_valid", 32'(bus.res_valid), 1);
    chk("done start result", 32'(bus.result), 2);
    ack_now("div6by3");

    issue(OP_SHL, 3'd3, 3'd0, 4'd3, 4'd3, 1'b0, 3, 0, 1'b0, 1'b1, c0);
    wait_valid("shl_by0");
    ack_now("shl_by0");

    issue(OP_ZERO, 3'd5, 3'd0, 4'd0, 4'd0, 1'b0, 5, 0, 1'b1, 1'b1, c0);
    @(negedge clk);
    chk("start+ack ready", 32'(bus.ready), 0);
    chk("start+ack alu_a", 32'(bus.alu_a), 5);
    chk("start+ack alu_op", 32'(bus.alu_op), 2);
    wait_valid("zero_a5");
    ack_now("zero_a5");

    repeat (5) @(posedge clk);
    #1;
    chk("pending results", 32'(res_q.size()), 0);
    chk("pending inits", 32'(init_q.size()), 0);
    chk("pending pulses", 32'(sh_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by time 100000, expected earlier finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
